// File: rtl/intr_ctrl_pkg.sv
// Shared constants and types for the eight-source interrupt controller.
package intr_ctrl_pkg;

  localparam int NUM_IRQ = 8;

  localparam logic [1:0] INTR_ENABLE_ADDR  = 2'd0;
  localparam logic [1:0] INTR_MODE_ADDR    = 2'd1;
  localparam logic [1:0] INTR_PENDING_ADDR = 2'd2;
  localparam logic [1:0] INTR_STATUS_ADDR  = 2'd3;

  typedef logic [2:0] intr_vec_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational 8->3 priority encoder; the index named by base has top priority,
// then priority descends with increasing index modulo 8.
module intr_prio_enc (
  input  logic [7:0] req,
  input  logic [2:0] base,
  output logic       valid,
  output logic [2:0] idx
);
  import intr_ctrl_pkg::*;

  logic [2*NUM_IRQ-1:0] dbl;
  logic [NUM_IRQ-1:0]   rot;
  intr_vec_t            off;

  // Rotate so that base lands on bit 0, pick the lowest set bit, then undo the rotation.
  always_comb begin
    dbl   = {req, req} >> base;
    rot   = dbl[NUM_IRQ-1:0];
    valid = |rot;
    off   = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = intr_vec_t'(i);
      end else begin
        off = off;
      end
    end
    idx = off + base;
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller top: edge/level capture, masking, 4-register bus and ACK handshake.
// Define INTR_CTRL_ROTATE_PRIO_EN for round-robin priority; otherwise index 0 is highest.
module intr_ctrl #(
  parameter int         NUM_IRQ    = 8,
  parameter logic [7:0] ENABLE_RST = 8'h00
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [NUM_IRQ-1:0] IREQ,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [1:0]         addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  input  logic               ACK,
  output logic [2:0]         VEC,
  output logic               IRQ
);
  import intr_ctrl_pkg::*;

  logic [NUM_IRQ-1:0] en_q, en_d, mode_q, mode_d, pend_q, pend_d;
  logic [NUM_IRQ-1:0] ireq_dly_q, ireq_dly_d;
  logic [NUM_IRQ-1:0] rise, w1c, ack_clr, active;
  logic [7:0]         rdata_q, rdata_d;
  logic               irq_q, irq_d, ack_ok, act_valid;
  intr_vec_t          vec_q, vec_d, act_idx, ptr;

  always_comb begin
    en_d       = en_q;
    mode_d     = mode_q;
    rdata_d    = rdata_q;
    w1c        = 8'h00;
    ireq_dly_d = IREQ;
    ack_ok     = ACK & irq_q;
    if (wr_en) begin
      case (addr)
        INTR_ENABLE_ADDR:  en_d   = wdata;
        INTR_MODE_ADDR:    mode_d = wdata;
        INTR_PENDING_ADDR: w1c    = wdata;
        default:           w1c    = 8'h00;
      endcase
    end else begin
      w1c = 8'h00;
    end
    if (rd_en) begin
      case (addr)
        INTR_ENABLE_ADDR:  rdata_d = en_q;
        INTR_MODE_ADDR:    rdata_d = mode_q;
        INTR_PENDING_ADDR: rdata_d = pend_q;
        default:           rdata_d = {irq_q, 4'b0000, vec_q};
      endcase
    end else begin
      rdata_d = rdata_q;
    end
    rise    = IREQ & ~ireq_dly_q;
    ack_clr = ack_ok ? (8'h01 << vec_q) : 8'h00;
    // Next-cycle mode decides level tracking; a level->edge switch (mode_q=0) clears the bit.
    pend_d  = (~mode_d & IREQ)
            | (mode_d & mode_q & (rise | (pend_q & ~(w1c | ack_clr))));
  end

  assign active = pend_q & en_q;

  intr_prio_enc u_prio_enc (
    .req   (active),
    .base  (ptr),
    .valid (act_valid),
    .idx   (act_idx)
  );

  always_comb begin
    irq_d = act_valid;
    vec_d = act_valid ? act_idx : vec_q;
  end

`ifdef INTR_CTRL_ROTATE_PRIO_EN
  intr_vec_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ack_ok ? (vec_q + 3'd1) : ptr_q;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 3'd0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_q       <= ENABLE_RST;
      mode_q     <= 8'h00;
      pend_q     <= 8'h00;
      ireq_dly_q <= 8'h00;
      rdata_q    <= 8'h00;
      irq_q      <= 1'b0;
      vec_q      <= 3'd0;
    end else begin
      en_q       <= en_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      ireq_dly_q <= ireq_dly_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      vec_q      <= vec_d;
    end
  end

  assign rdata = rdata_q;
  assign VEC   = vec_q;
  assign IRQ   = irq_q;

endmodule
